// File: rtl/dot_product_bf16_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dot_product_bf16_if
// Description : Request/result handshake bundle for the bf16 dot-product
//               engine. The master side (command decoder / writeback) drives
//               the operands and the downstream busy. The slave side (the
//               engine) drives the request busy, the result and its strobe.
//   input_a / input_b   : N_PAIRS packed bf16 operands, pair k at [16k+15:16k]
//   mode                : 0 = plain sum, 1 = odd pairs subtracted
//   op_input_STB        : request valid (master -> slave)
//   op_BUSY             : request in flight (slave -> master)
//   output_result       : bf16 result (slave -> master)
//   op_output_STB       : result valid (slave -> master)
//   output_module_BUSY  : downstream busy (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_bf16_if #(
    parameter int N_PAIRS = 2
);
    logic [16*N_PAIRS-1:0] input_a;
    logic [16*N_PAIRS-1:0] input_b;
    logic                  mode;
    logic                  op_input_STB;
    logic                  op_BUSY;
    logic [15:0]           output_result;
    logic                  op_output_STB;
    logic                  output_module_BUSY;

    modport master (
        output input_a, input_b, mode, op_input_STB, output_module_BUSY,
        input  op_BUSY, output_result, op_output_STB
    );

    modport slave (
        input  input_a, input_b, mode, op_input_STB, output_module_BUSY,
        output op_BUSY, output_result, op_output_STB
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_bf16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dot_product_bf16 (with dot_product_bf16_pkg, multiplier_bf16,
//               adder_bf16)
// Description : Sequential bf16 dot product. One multiplier and one adder are
//               time-multiplexed by a single FSM; products are accumulated in
//               strict k = 0..N_PAIRS-1 order, odd products negated in mode 1.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : dot_product_bf16_if.slave request/result handshake
// Arithmetic: round-to-nearest-even, denormal inputs/results flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_product_bf16_pkg;
    // Rounds a normalised significand; the exponent/fraction concatenation
    // lets a rounding carry ripple straight into the exponent.
    function automatic logic [15:0] bf16_round(input logic s, input logic signed [9:0] e,
                                               input logic [6:0] kept, input logic g,
                                               input logic st);
        logic [16:0] r;
        r = {e, kept} + 17'(g & (st | kept[0]));
        if ($signed(r[16:7]) <= 10'sd0)        return {s, 15'h0000};
        else if ($signed(r[16:7]) >= 10'sd255) return {s, 8'hFF, 7'h00};
        else                                   return {s, r[14:0]};
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic              s;
        logic [15:0]       prod;
        logic signed [9:0] e;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'hFF && a[6:0] != 7'h00) return a | 16'h0040;
        if (b[14:7] == 8'hFF && b[6:0] != 7'h00) return b | 16'h0040;
        if (a[14:7] == 8'hFF || b[14:7] == 8'hFF)
            return (a[14:7] == 8'h00 || b[14:7] == 8'h00) ? 16'h7FC0 : {s, 8'hFF, 7'h00};
        if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {s, 15'h0000};
        prod = {1'b1, a[6:0]} * {1'b1, b[6:0]};
        e    = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
        if (prod[15]) return bf16_round(s, e + 10'sd1, prod[14:8], prod[7], |prod[6:0]);
        else          return bf16_round(s, e, prod[13:7], prod[6], |prod[5:0]);
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]       x, y;
        logic [7:0]        d;
        logic [34:0]       xw, yw, sum, n;
        logic signed [9:0] e;
        int                lz;
        if (a[14:7] == 8'hFF && a[6:0] != 7'h00) return a | 16'h0040;
        if (b[14:7] == 8'hFF && b[6:0] != 7'h00) return b | 16'h0040;
        if (a[14:7] == 8'hFF && b[14:7] == 8'hFF && a[15] != b[15]) return 16'h7FC0;
        if (a[14:7] == 8'hFF) return a;
        if (b[14:7] == 8'hFF) return b;
        if (a[14:7] == 8'h00) return (b[14:7] == 8'h00) ? 16'h0000 : b;
        if (b[14:7] == 8'h00) return a;
        // x carries the larger magnitude, so the result takes its sign
        if (a[14:0] < b[14:0]) begin x = b; y = a; end
        else                   begin x = a; y = b; end
        d  = x[14:7] - y[14:7];
        xw = {1'b0, 1'b1, x[6:0], 26'h0};
        // 26 spare bits hold any alignment exactly; beyond that y only
        // influences rounding, which a single sticky LSB reproduces
        yw = (d >= 8'd27) ? 35'd1 : ({1'b0, 1'b1, y[6:0], 26'h0} >> d);
        sum = (x[15] ^ y[15]) ? (xw - yw) : (xw + yw);
        if (sum == 35'd0) return 16'h0000;
        lz = 0;
        for (int i = 0; i < 35; i++) if (sum[i]) lz = 34 - i;
        n = sum << lz;
        e = $signed({2'b00, x[14:7]}) + 10'sd1 - 10'(lz);
        return bf16_round(x[15], e, n[33:27], n[26], |n[25:0]);
    endfunction
endpackage

module multiplier_bf16 (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [15:0] input_a,
    input  wire logic [15:0] input_b,
    input  wire logic        input_STB,
    output logic             input_BUSY,
    output logic [15:0]      output_z,
    output logic             output_z_STB,
    input  wire logic        output_z_BUSY
);
    logic [15:0] z_q, z_d;
    logic        stb_q, stb_d;

    // One request in flight: the input side is busy while a result waits.
    always_comb begin
        z_d   = z_q;
        stb_d = stb_q;
        if (stb_q && !output_z_BUSY) begin
            stb_d = 1'b0;
        end else if (!stb_q && input_STB) begin
            stb_d = 1'b1;
            z_d   = dot_product_bf16_pkg::bf16_mul(input_a, input_b);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q   <= 16'h0000;
            stb_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            stb_q <= stb_d;
        end
    end

    assign input_BUSY   = stb_q;
    assign output_z     = z_q;
    assign output_z_STB = stb_q;
endmodule

module adder_bf16 (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [15:0] input_a,
    input  wire logic [15:0] input_b,
    input  wire logic        input_STB,
    output logic             input_BUSY,
    output logic [15:0]      output_z,
    output logic             output_z_STB,
    input  wire logic        output_z_BUSY
);
    logic [15:0] z_q, z_d;
    logic        stb_q, stb_d;

    always_comb begin
        z_d   = z_q;
        stb_d = stb_q;
        if (stb_q && !output_z_BUSY) begin
            stb_d = 1'b0;
        end else if (!stb_q && input_STB) begin
            stb_d = 1'b1;
            z_d   = dot_product_bf16_pkg::bf16_add(input_a, input_b);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q   <= 16'h0000;
            stb_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            stb_q <= stb_d;
        end
    end

    assign input_BUSY   = stb_q;
    assign output_z     = z_q;
    assign output_z_STB = stb_q;
endmodule

module dot_product_bf16 #(
    parameter int N_PAIRS = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dot_product_bf16_if.slave  bus
);
    localparam int            KW     = $clog2(N_PAIRS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_PAIRS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE_MUL = 3'd1;
    localparam logic [2:0] S_WAIT_MUL  = 3'd2;
    localparam logic [2:0] S_ISSUE_ADD = 3'd3;
    localparam logic [2:0] S_WAIT_ADD  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    if (N_PAIRS < 1 || N_PAIRS > 16) begin : g_bad_n_pairs
        $error("dot_product_bf16: N_PAIRS must lie in 1..16");
    end

    logic [2:0]                state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [15:0]               acc_q, acc_d;
    logic [15:0]               p_q, p_d;
    logic [N_PAIRS-1:0][15:0]  a_q, a_d, b_q, b_d;
    logic                      mode_q, mode_d;

    logic        mul_in_stb, mul_in_busy, mul_out_stb, mul_out_busy;
    logic        add_in_stb, add_in_busy, add_out_stb, add_out_busy;
    logic [15:0] mul_a, mul_b, mul_z, add_z, signed_prod;

    multiplier_bf16 u_mul (
        .clk(clk), .rst(rst),
        .input_a(mul_a), .input_b(mul_b), .input_STB(mul_in_stb), .input_BUSY(mul_in_busy),
        .output_z(mul_z), .output_z_STB(mul_out_stb), .output_z_BUSY(mul_out_busy)
    );

    adder_bf16 u_add (
        .clk(clk), .rst(rst),
        .input_a(acc_q), .input_b(p_q), .input_STB(add_in_stb), .input_BUSY(add_in_busy),
        .output_z(add_z), .output_z_STB(add_out_stb), .output_z_BUSY(add_out_busy)
    );

    // Odd-indexed products are negated in alternating mode (NaN included).
    assign signed_prod = mul_z ^ {mode_q & k_q[0], 15'h0000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= 16'h0000;
            p_q     <= 16'h0000;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: if (bus.op_input_STB) begin
                a_d     = bus.input_a;
                b_d     = bus.input_b;
                mode_d  = bus.mode;
                k_d     = '0;
                state_d = S_ISSUE_MUL;
            end
            S_ISSUE_MUL: if (!mul_in_busy) state_d = S_WAIT_MUL;
            S_WAIT_MUL: if (mul_out_stb) begin
                // The first product seeds the accumulator directly.
                if (k_q == '0) begin
                    acc_d = signed_prod;
                    if (N_PAIRS == 1) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_ISSUE_MUL;
                    end
                end else begin
                    p_d     = signed_prod;
                    state_d = S_ISSUE_ADD;
                end
            end
            S_ISSUE_ADD: if (!add_in_busy) state_d = S_WAIT_ADD;
            S_WAIT_ADD: if (add_out_stb) begin
                acc_d = add_z;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_ISSUE_MUL;
                end
            end
            S_DONE: if (!bus.output_module_BUSY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_a = 16'h0000;
        mul_b = 16'h0000;
        for (int i = 0; i < N_PAIRS; i++) begin
            if (k_q == KW'(i)) begin
                mul_a = a_q[i];
                mul_b = b_q[i];
            end
        end
        mul_in_stb        = (state_q == S_ISSUE_MUL);
        mul_out_busy      = (state_q != S_WAIT_MUL);
        add_in_stb        = (state_q == S_ISSUE_ADD);
        add_out_busy      = (state_q != S_WAIT_ADD);
        bus.op_BUSY       = (state_q != S_IDLE);
        bus.op_output_STB = (state_q == S_DONE);
        bus.output_result = acc_q;
    end
endmodule
`default_nettype wire
